// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART byte transmitter
// between NUM_REQ word-level requesters, sending each word LSB byte first.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous, active-low reset
//   req         - level request per requester, held until its done_pulse
//   req_data    - flattened words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant       - one-hot owner of the transmitter, zero when idle
//   busy        - high whenever a word is in flight
//   done_pulse  - one-cycle pulse to the owner after its last byte
//   byte_data   - byte presented to the transmitter
//   byte_start  - level transmit request to the transmitter
//   byte_done   - sticky end flag from the transmitter
//   byte_clr_n  - active-low clear of byte_done
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [NUM_REQ-1:0]            done_pulse,
    output logic [BYTE_W-1:0]             byte_data,
    output logic                          byte_start,
    input  logic                          byte_done,
    output logic                          byte_clr_n
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_DONE,
        S_CLEAR,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [BYTE_W-1:0]       data_q, data_d;
    logic                    start_q, start_d;
    logic                    clr_n_q, clr_n_d;
    logic                    busy_q, busy_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;

    // Round-robin pick: first set req scanning upward from rr_q.
    // cand is one bit wider so rr_q + i never overflows before the wrap.
    logic                    sel_vld;
    logic [PTR_W-1:0]        sel_idx;
    logic [PTR_W:0]          cand;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        data_d  = data_q;
        start_d = start_q;
        clr_n_d = clr_n_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        word_d  = word_q;

        unique case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    owner_d          = sel_idx;
                    word_d  = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = word_q[BYTE_W-1:0];
                start_d = 1'b1;
                clr_n_d = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (byte_done) begin
                    start_d = 1'b0;
                    clr_n_d = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Stay here until the sticky flag is really gone so the
                // next LOAD cannot see a stale completion.
                if (!byte_done) begin
                    clr_n_d = 1'b1;
                    if (idx_q == IDX_W'(BYTES_PER_WORD-1)) begin
                        done_d  = grant_q;
                        state_d = S_FINISH;
                    end else begin
                        word_d  = word_q >> BYTE_W;
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FINISH: begin
                grant_d = '0;
                if (owner_q == PTR_W'(NUM_REQ-1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = owner_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            clr_n_q <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            data_q  <= data_d;
            start_q <= start_d;
            clr_n_q <= clr_n_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            word_q  <= word_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;
    assign byte_data  = data_q;
    assign byte_start = start_q;
    assign byte_clr_n = clr_n_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a
// sticky-flag byte transmitter model and per-word logging.
module tb_uart_tx_arbiter;

    localparam int TX_DELAY = 10;
    localparam int MAXW     = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] req_data;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  done_pulse;
    logic [7:0]  byte_data;
    logic        byte_start;
    logic        byte_done;
    logic        byte_clr_n;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(2),
        .DATA_WIDTH(32),
        .BYTE_W(8),
        .BYTES_PER_WORD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .grant(grant),
        .busy(busy),
        .done_pulse(done_pulse),
        .byte_data(byte_data),
        .byte_start(byte_start),
        .byte_done(byte_done),
        .byte_clr_n(byte_clr_n)
    );

    // Transmitter model: done TX_DELAY cycles after start, flag held
    // for sticky_hold extra cycles after the clear is seen.
    int   tx_cnt;
    logic tx_act;
    int   hold_cnt;
    int   sticky_hold = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_done <= 1'b0;
            tx_cnt    <= 0;
            tx_act    <= 1'b0;
            hold_cnt  <= 0;
        end else begin
            if (!byte_clr_n) begin
                if (hold_cnt >= sticky_hold) byte_done <= 1'b0;
                else hold_cnt <= hold_cnt + 1;
            end else begin
                hold_cnt <= 0;
            end
            if (tx_act) begin
                if (tx_cnt == TX_DELAY-1) begin
                    byte_done <= 1'b1;
                    tx_act    <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt + 1;
                end
            end else if (byte_start && !byte_done) begin
                tx_act <= 1'b1;
                tx_cnt <= 0;
            end
        end
    end

    // Monitor
    logic [7:0] byte_q[$];
    logic [1:0] gnt_q[$];
    logic [1:0] pulse_q[$];
    int   viol;
    int   clr_low;
    logic prev_start = 1'b0;
    logic prev_clrn  = 1'b1;
    logic prev_done  = 1'b0;

    always @(negedge clk) begin
        if ($countones(grant) > 1) viol++;
        if (byte_start && !byte_clr_n) viol++;
        if (done_pulse != 0 && (done_pulse !== grant || !busy)) viol++;
        if (byte_clr_n && !prev_clrn && prev_done) viol++;
        if (byte_start && !prev_start) begin
            if (byte_done) viol++;
            byte_q.push_back(byte_data);
            gnt_q.push_back(grant);
        end
        if (done_pulse != 0) pulse_q.push_back(done_pulse);
        if (!byte_clr_n) clr_low++;
        prev_start = byte_start;
        prev_clrn  = byte_clr_n;
        prev_done  = byte_done;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        byte_q.delete();
        gnt_q.delete();
        pulse_q.delete();
        viol    = 0;
        clr_low = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic wait_pulse(output logic [1:0] who);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_pulse == 2'b00 && n < MAXW);
        check("pulse_seen", 32'(done_pulse != 2'b00), 32'd1);
        who = done_pulse;
    endtask

    function automatic logic [31:0] pack(input int b);
        if (byte_q.size() < b + 4) return 32'h0;
        return {byte_q[b+3], byte_q[b+2], byte_q[b+1], byte_q[b]};
    endfunction

    function automatic logic [7:0] gpat(input logic [1:0] g);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < gnt_q.size() && i < 8; i++) begin
            p[i] = (gnt_q[i] == g);
        end
        return p;
    endfunction

    logic [1:0] who;
    logic [7:0] seq;
    int         n;

    initial begin
        reset    = 1'b0;
        req      = 2'b00;
        req_data = '0;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_start", 32'(byte_start), 32'h0);
        check("rst_clr_n", 32'(byte_clr_n), 32'h1);
        check("rst_done", 32'(done_pulse), 32'h0);
        check("rst_data", 32'(byte_data), 32'h0);

        // 1: single word, latency
        req_data[31:0] = 32'h44332211;
        req = 2'b01;
        @(posedge clk); #1;
        check("t1_start_lat1", 32'(byte_start), 32'h0);
        @(posedge clk); #1;
        check("t1_start_lat2", 32'(byte_start), 32'h1);
        wait_pulse(who);
        req = 2'b00;
        check("t1_who", 32'(who), 32'h1);
        repeat (3) @(negedge clk);
        check("t1_nbytes", byte_q.size(), 32'd4);
        check("t1_bytes", pack(0), 32'h44332211);
        check("t1_grant", 32'(gpat(2'b01)), 32'h0F);
        check("t1_pulses", pulse_q.size(), 32'd1);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_grant_idle", 32'(grant), 32'h0);
        check("t1_clr_low", clr_low, 32'd8);
        check("t1_viol", viol, 32'd0);

        // 2: simultaneous requests from reset
        do_reset();
        req_data = {32'hB1B1B1B1, 32'hA0A0A0A0};
        req = 2'b11;
        wait_pulse(who);
        req = req & ~who;
        check("t2_first", 32'(who), 32'h1);
        wait_pulse(who);
        req = req & ~who;
        check("t2_second", 32'(who), 32'h2);
        repeat (3) @(negedge clk);
        check("t2_nbytes", byte_q.size(), 32'd8);
        check("t2_word0", pack(0), 32'hA0A0A0A0);
        check("t2_word1", pack(4), 32'hB1B1B1B1);
        check("t2_g01", 32'(gpat(2'b01)), 32'h0F);
        check("t2_g10", 32'(gpat(2'b10)), 32'hF0);
        check("t2_viol", viol, 32'd0);

        // 3: fairness with req held high
        do_reset();
        req_data = {32'h05060708, 32'h01020304};
        req = 2'b11;
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(who);
            seq[k*2 +: 2] = who;
        end
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("t3_order", 32'(seq), 32'h99);
        check("t3_nbytes", byte_q.size(), 32'd16);
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_viol", viol, 32'd0);

        // 4: sticky flag held after clear
        sticky_hold = 3;
        do_reset();
        req_data[31:0] = 32'hC3D2E1F0;
        req = 2'b01;
        wait_pulse(who);
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("t4_who", 32'(who), 32'h1);
        check("t4_bytes", pack(0), 32'hC3D2E1F0);
        check("t4_clr_low", clr_low, 32'd20);
        check("t4_viol", viol, 32'd0);
        sticky_hold = 0;

        // 5: data and req change mid-word
        do_reset();
        req_data[31:0] = 32'h12345678;
        req = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_done && n < MAXW);
        check("t5_first_done", 32'(byte_done), 32'h1);
        req_data[31:0] = 32'hDEADBEEF;
        req = 2'b00;
        wait_pulse(who);
        check("t5_who", 32'(who), 32'h1);
        repeat (3) @(negedge clk);
        check("t5_bytes", pack(0), 32'h12345678);
        check("t5_nbytes", byte_q.size(), 32'd4);
        check("t5_viol", viol, 32'd0);

        // 6: reset mid-transfer
        do_reset();
        req_data = {32'h5A5B5C5D, 32'h0F0E0D0C};
        req = 2'b01;
        wait_pulse(who);
        req = 2'b00;
        repeat (2) @(negedge clk);
        req = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (byte_q.size() < 6 && n < MAXW);
        check("t6_reached_b2", byte_q.size(), 32'd6);
        reset = 1'b0;
        #1;
        check("t6_grant", 32'(grant), 32'h0);
        check("t6_start", 32'(byte_start), 32'h0);
        check("t6_clr_n", 32'(byte_clr_n), 32'h1);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_done", 32'(done_pulse), 32'h0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_pulses", pulse_q.size(), 32'd1);
        clear_logs();
        req = 2'b11;
        wait_pulse(who);
        req = req & ~who;
        check("t6_restart_who", 32'(who), 32'h1);
        wait_pulse(who);
        req = req & ~who;
        check("t6_second_who", 32'(who), 32'h2);
        repeat (3) @(negedge clk);
        check("t6_word0", pack(0), 32'h0F0E0D0C);
        check("t6_word1", pack(4), 32'h5A5B5C5D);
        check("t6_viol", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART byte transmitter between NUM_REQ word-level requesters, e.g. the MIPS store path and a debug/trace source.
- Latches the granted requester's 32-bit word.
- Sends it LSB byte first, BYTES_PER_WORD bytes, using the byte transmitter's start / end-flag / active-low-clear handshake.
- Returns a one-cycle done pulse to that requester.
- Sits between the memory-mapped UART registers and the byte-level TX unit, which is instantiated outside this block.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, word width per requester
BYTE_W, 8, transmitter byte width
BYTES_PER_WORD, 4, bytes sent per word; DATA_WIDTH = BYTE_W*BYTES_PER_WORD

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until its done_pulse
req_data  in  NUM_REQ*DATA_WIDTH  flattened words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle
busy  out  1  high in every state except IDLE
done_pulse  out  NUM_REQ  one-cycle pulse to owner when its last byte completes
byte_data  out  BYTE_W  byte presented to transmitter
byte_start  out  1  transmit request to transmitter (level)
byte_done  in  1  transmitter end flag; sticky until cleared
byte_clr_n  out  1  active-low clear of byte_done

Behaviour:
- Reset values (asynchronous): state=IDLE, grant=0, done_pulse=0, byte_data=0, byte_start=0, byte_clr_n=1, byte_idx=0, rr_ptr=0 (requester 0 has highest priority), word register=0.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_DONE, CLEAR, FINISH.
- IDLE:
  - If any req bit is high, select the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - Set grant one-hot for it, latch its req_data into the word register, byte_idx=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: byte_data<=word[BYTE_W-1:0], byte_start<=1, byte_clr_n<=1, go to WAIT_DONE.
- WAIT_DONE:
  - Hold byte_start=1 while byte_done=0.
  - When byte_done=1: byte_start<=0, byte_clr_n<=0, go to CLEAR.
- CLEAR:
  - Hold byte_clr_n=0 until byte_done is sampled 0; then byte_clr_n<=1.
  - If byte_idx==BYTES_PER_WORD-1, go to FINISH.
  - Else shift word right by BYTE_W (zero fill), byte_idx++, go to LOAD.
- FINISH:
  - done_pulse[owner]=1 for exactly this cycle.
  - grant<=0, rr_ptr<=(owner+1) mod NUM_REQ, go to IDLE.
- Latency:
  - req seen in IDLE -> byte_start high 2 cycles later.
  - Minimum inter-byte gap after byte_done rises: 3 cycles (CLEAR, LOAD, start).
  - Last byte_done -> done_pulse: 2 cycles minimum.
- Word capture: the word is captured only in IDLE; later changes to req_data are ignored for the rest of that word.
- Req dropped by the owner mid-transfer: ignored; the word completes and done_pulse still fires.
- Simultaneous requests: exactly one grant, chosen by rr_ptr; losers keep req high and are served in later rounds. No requester waits more than NUM_REQ-1 words.
- Req re-sampling after FINISH: IDLE re-samples req on the cycle after FINISH. A requester must drop req on the edge where it sees done_pulse; if req is still high in IDLE, that is a new request.
- byte_done already high on entry to WAIT_DONE (stale flag): treated as completion. To prevent this, CLEAR guarantees byte_done is low before LOAD.
- Reset asserted mid-word: immediate return to reset values, no done_pulse, partial word discarded; the transmitter is reset by the same net.
- Invariants:
  - grant is always zero or one-hot.
  - byte_start and byte_clr_n=0 are never both asserted.
  - done_pulse is never asserted outside FINISH.

Test Plan:
1. Single word: req=2'b01, word0=0x44332211, transmitter model raising byte_done 10 cycles after byte_start. Required: byte_data sequence 0x11,0x22,0x33,0x44, one byte_start rise per byte, done_pulse=2'b01 for 1 cycle, grant=2'b01 throughout then 0, busy low after.
2. Simultaneous requests from reset: req=2'b11, word0=0xA0A0A0A0, word1=0xB1B1B1B1, each requester dropping req on its done_pulse. Required: requester 0 served first (rr_ptr=0), then requester 1; all 4 bytes of a word precede any byte of the other.
3. Fairness: req held at 2'b11 continuously for 4 words. Required: grants alternate 01,10,01,10.
4. Stale and sticky flag: transmitter model holds byte_done high for 3 cycles after byte_clr_n falls. Required: byte_clr_n stays low until byte_done samples 0, and no early LOAD.
5. Word and req changes during transfer: change req_data and drop req after byte 1 of word 0x12345678. Required: bytes 0x78,0x56,0x34,0x12 still sent and done_pulse fires.
6. Reset mid-transfer: assert reset during byte 2. Required: grant=0, byte_start=0, byte_clr_n=1, busy=0, no done_pulse. A subsequent request restarts at byte 0 with requester 0 priority.
